uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single 4-entry UART TX FIFO between NUM_REQ byte-stream requesters
//  (e.g. stopwatch time report, RX echo, status messages). Whole messages are
//  granted round-robin, so bytes from different sources never interleave.
//  Sits between the message generators and the TX FIFO push port.
// PARAMETERS
//  NUM_REQ  2    number of requesters (2..8)
//  DATA_W   8    byte width, matches FIFO push_data
//  MAX_LEN  16   max bytes per message before forced release (>=1)
// PORTS
//  clk            in   1                system clock
//  rst            in   1                reset
//  req_valid      in   NUM_REQ          requester i has a byte on req_data
//  req_data       in   NUM_REQ*DATA_W   byte of requester i at [i*DATA_W +: DATA_W]
//  req_last       in   NUM_REQ          current byte of requester i ends its message
//  req_ready      out  NUM_REQ          byte of requester i accepted this cycle
//  fifo_full      in   1                TX FIFO full flag
//  fifo_push      out  1                push strobe to TX FIFO
//  fifo_push_data out  DATA_W           byte to TX FIFO
//  grant_id       out  clog2(NUM_REQ)   index of owner (valid while busy)
//  busy           out  1                a message is locked
//  err_len        out  1                1-cycle pulse: message forced off at MAX_LEN
// BEHAVIOUR
//  Reset rst, asynchronous, active-high; clock clk. Reset: state IDLE, rr_ptr=0,
//   grant_id=0, busy=0, byte_cnt=0, err_len=0; fifo_push=0, req_ready=0.
//  FSM IDLE: if any req_valid, pick first valid index searching from rr_ptr
//   upward with wrap; next cycle state LOCK, grant_id=pick, busy=1, byte_cnt=0.
//   No transfer in IDLE (arbitration costs exactly 1 cycle).
//  FSM LOCK (owner g = grant_id): xfer = req_valid[g] & ~fifo_full (comb).
//   fifo_push = xfer; fifo_push_data = req_data[g]; req_ready[g] = xfer;
//   req_ready of all other indices = 0. Zero-latency pass-through, no buffering.
//  On xfer: byte_cnt++. If req_last[g] -> IDLE, rr_ptr = g+1 (wrap NUM_REQ).
//   Else if byte_cnt+1 == MAX_LEN -> IDLE, rr_ptr = g+1, err_len=1 next cycle.
//  fifo_full in LOCK: stall, grant held, no push, byte_cnt unchanged.
//  Owner drops req_valid mid-message: grant held indefinitely (no timeout).
//  Requester with no valid in IDLE is skipped; single requester is re-granted
//   after one IDLE cycle between messages.
//  fifo_push is never asserted while fifo_full=1 or in IDLE.
//  Reset mid-message: immediate abort to IDLE, partial message not resumed.
//  byte_cnt width clog2(MAX_LEN+1); rr_ptr/grant_id wrap modulo NUM_REQ.
// STRUCTURE
//  Shared package: DATA_W, FSM state encoding (IDLE/LOCK), clog2 helper.
//  Sub-module rr_priority_picker: comb, inputs req vector + rr_ptr,
//   outputs pick index + any_valid. Remaining FSM/counter in this module.
// TESTING
//  1. Req0 sends 3 bytes 0x31,0x32,0x0A (last on 0x0A), fifo never full ->
//     1 idle cycle then 3 consecutive pushes, grant_id=0, busy drops after 0x0A.
//  2. Req0 and Req1 both valid from reset -> Req0 message fully pushed first,
//     then Req1; next simultaneous pair starts with Req0 again (rr_ptr wrapped).
//  3. fifo_full forced 1 for 5 cycles mid-message -> no push, req_ready=0,
//     grant held; resume pushes the stalled byte exactly once.
//  4. Req1 streams 20 bytes without last, MAX_LEN=16 -> 16 pushes, err_len
//     pulses once, Req0 (waiting) granted next.
//  5. rst asserted after 2 of 4 bytes -> outputs at reset values same cycle,
//     busy=0, no further push until new arbitration.
//  6. Owner drops req_valid for 3 cycles mid-message while Req1 valid ->
//     grant stays with owner, no Req1 byte pushed until owner's last.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared definitions for the UART TX arbiter slice: default byte width,
//   arbiter FSM state encoding and width helpers used for port/counter sizing.
//   No ports (package).
package uart_tx_arbiter_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// rr_priority_picker
//   Combinational round-robin picker: returns the first asserted request
//   searching upward from rr_ptr with wrap-around.
//   Ports:
//     req       in  NUM_REQ  request vector
//     rr_ptr    in  IDX_W    index with highest priority
//     pick      out IDX_W    chosen index (0 when nothing requested)
//     any_valid out 1        at least one request asserted
module rr_priority_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   pick,
  output logic               any_valid
);

  // rot[k] is the request k positions after rr_ptr; rot_idx[k] its real index.
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   rot_idx [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] idx;
      assign sum = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
      assign idx = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                : sum[IDX_W-1:0];
      assign rot[gi]     = req[idx];
      assign rot_idx[gi] = idx;
    end
  endgenerate

  // Scan from the far end so the closest request to rr_ptr wins.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pick      = rot_idx[k];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares the single TX FIFO push port between NUM_REQ byte-stream sources.
//   Whole messages are granted round-robin; the owner's bytes pass straight
//   through to the FIFO with no buffering. A message longer than MAX_LEN is
//   forcibly released and flagged with err_len.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     req_valid/data/last, req_ready   per-requester byte handshake
//     fifo_full, fifo_push, fifo_push_data   TX FIFO push port
//     grant_id        current / last owner index
//     busy            a message is locked
//     err_len         1-cycle pulse after a forced release at MAX_LEN
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_LEN = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_push,
  output logic [DATA_W-1:0]           fifo_push_data,
  output logic [idx_w(NUM_REQ)-1:0]   grant_id,
  output logic                        busy,
  output logic                        err_len
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = clog2(MAX_LEN + 1);

  arb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic             err_len_reg, err_len_next;

  logic [IDX_W-1:0] pick;
  logic             any_valid;
  logic             xfer;
  logic [CNT_W-1:0] cnt_inc;
  logic [IDX_W-1:0] ptr_after;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .pick      (pick),
    .any_valid (any_valid)
  );

  // Byte moves only while locked, owner presents data and FIFO has room.
  assign xfer           = (state_reg == LOCK) && req_valid[grant_reg] && !fifo_full;
  assign fifo_push      = xfer;
  assign fifo_push_data = req_data[grant_reg*DATA_W +: DATA_W];
  assign cnt_inc        = byte_cnt_reg + 1'b1;
  assign ptr_after      = (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = xfer && (grant_reg == IDX_W'(gi));
    end
  endgenerate

  assign grant_id = grant_reg;
  assign busy     = (state_reg == LOCK);
  assign err_len  = err_len_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      byte_cnt_reg <= '0;
      err_len_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      byte_cnt_reg <= byte_cnt_next;
      err_len_reg  <= err_len_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    byte_cnt_next = byte_cnt_reg;
    err_len_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        // Arbitration cycle: no byte is moved here.
        if (any_valid) begin
          state_next    = LOCK;
          grant_next    = pick;
          byte_cnt_next = '0;
        end
      end
      LOCK: begin
        // Stalls (FIFO full or owner idle) simply hold everything.
        if (xfer) begin
          byte_cnt_next = cnt_inc;
          if (req_last[grant_reg]) begin
            state_next  = IDLE;
            rr_ptr_next = ptr_after;
          end else if (cnt_inc == CNT_W'(MAX_LEN)) begin
            state_next   = IDLE;
            rr_ptr_next  = ptr_after;
            err_len_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        fifo_full;
  logic        fifo_push;
  logic [7:0]  fifo_push_data;
  logic [0:0]  grant_id;
  logic        busy;
  logic        err_len;

  uart_tx_arbiter #(
    .NUM_REQ (2),
    .DATA_W  (8),
    .MAX_LEN (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .fifo_full      (fifo_full),
    .fifo_push      (fifo_push),
    .fifo_push_data (fifo_push_data),
    .grant_id       (grant_id),
    .busy           (busy),
    .err_len        (err_len)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic last; } src_byte_t;
  typedef struct packed { logic src; logic [7:0] d; } exp_t;

  src_byte_t q0[$];
  src_byte_t q1[$];
  exp_t      exp_q[$];

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         err_cnt = 0;
  int         push_total = 0;
  int         push_at_err = 0;
  logic [1:0] mask = 2'b00;
  logic [1:0] acc_drv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h required 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Requester model: present the head of each source queue, pop on acceptance.
  task automatic drive();
    req_valid[0] = (q0.size() != 0) && !mask[0];
    req_data[7:0] = (q0.size() != 0) ? q0[0].d : 8'h00;
    req_last[0]  = (q0.size() != 0) ? q0[0].last : 1'b0;
    req_valid[1] = (q1.size() != 0) && !mask[1];
    req_data[15:8] = (q1.size() != 0) ? q1[0].d : 8'h00;
    req_last[1]  = (q1.size() != 0) ? q1[0].last : 1'b0;
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc_drv = req_ready & req_valid;
      @(posedge clk);
      #1;
      if (acc_drv[0] && q0.size() != 0) void'(q0.pop_front());
      if (acc_drv[1] && q1.size() != 0) void'(q1.pop_front());
      drive();
    end
  end

  // Monitor: every push must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("push_while_full", {31'b0, fifo_push & fifo_full}, 32'd0);
        if (fifo_push) begin
          push_total++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_push @cyc %0d: got push data 0x%02h src %0d, required no push",
                     cyc, fifo_push_data, grant_id);
          end else begin
            e = exp_q.pop_front();
            $display("cyc %0d push src=%0d data=0x%02h (expect src=%0d data=0x%02h)",
                     cyc, grant_id, fifo_push_data, e.src, e.d);
            check("push_data", {24'b0, fifo_push_data}, {24'b0, e.d});
            check("push_grant", {31'b0, grant_id}, {31'b0, e.src});
          end
        end
        if (err_len) begin
          err_cnt++;
          push_at_err = push_total;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_tick(input int t);
    while (cyc < t) tick();
    check("sched_tick", cyc, t);
  endtask

  task automatic at_neg(input int t);
    do @(negedge clk); while (cyc < t);
    check("sched_neg", cyc, t);
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic ld_src(input int src, input logic [7:0] d, input logic last);
    src_byte_t b;
    b.d = d;
    b.last = last;
    if (src == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  task automatic ld_exp(input int src, input logic [7:0] d);
    exp_t e;
    e.src = src[0];
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 0);
    check({tag, "_push"}, {31'b0, fifo_push}, 0);
    check({tag, "_ready"}, {30'b0, req_ready}, 0);
    check({tag, "_grant"}, {31'b0, grant_id}, 0);
    check({tag, "_err"}, {31'b0, err_len}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int base;
    fifo_full = 1'b0;

    // Reset state
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;
    tick();

    // 1: single 3-byte message, one arbitration cycle then back-to-back pushes
    c0 = cyc;
    ld_src(0, 8'h31, 0); ld_src(0, 8'h32, 0); ld_src(0, 8'h0A, 1);
    ld_exp(0, 8'h31);    ld_exp(0, 8'h32);    ld_exp(0, 8'h0A);
    at_neg(c0 + 1);
    check("t1_idle_busy", {31'b0, busy}, 0);
    check("t1_idle_push", {31'b0, fifo_push}, 0);
    at_neg(c0 + 2);
    check("t1_lock_busy", {31'b0, busy}, 1);
    check("t1_push0", {31'b0, fifo_push}, 1);
    at_neg(c0 + 3);
    check("t1_push1", {31'b0, fifo_push}, 1);
    at_neg(c0 + 4);
    check("t1_push2", {31'b0, fifo_push}, 1);
    at_neg(c0 + 5);
    check("t1_release_busy", {31'b0, busy}, 0);
    check("t1_release_push", {31'b0, fifo_push}, 0);

    // 2: simultaneous requesters from reset, then a second pair after wrap
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    ld_src(0, 8'h41, 0); ld_src(0, 8'h42, 1);
    ld_src(1, 8'h61, 0); ld_src(1, 8'h62, 1);
    ld_exp(0, 8'h41); ld_exp(0, 8'h42); ld_exp(1, 8'h61); ld_exp(1, 8'h62);
    wait_drain(50);
    tick();
    ld_src(0, 8'h43, 1); ld_src(1, 8'h63, 1);
    ld_exp(0, 8'h43); ld_exp(1, 8'h63);
    wait_drain(50);

    // 3: FIFO full for 5 cycles mid-message
    tick();
    c0 = cyc;
    ld_src(0, 8'h50, 0); ld_src(0, 8'h51, 0); ld_src(0, 8'h52, 0); ld_src(0, 8'h53, 1);
    ld_exp(0, 8'h50); ld_exp(0, 8'h51); ld_exp(0, 8'h52); ld_exp(0, 8'h53);
    wait_tick(c0 + 4);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      at_neg(c0 + 4 + k);
      check("t3_stall_push", {31'b0, fifo_push}, 0);
      check("t3_stall_ready", {30'b0, req_ready}, 0);
      check("t3_stall_busy", {31'b0, busy}, 1);
      check("t3_stall_grant", {31'b0, grant_id}, 0);
    end
    wait_tick(c0 + 9);
    fifo_full = 1'b0;
    at_neg(c0 + 9);
    check("t3_resume_push", {31'b0, fifo_push}, 1);
    wait_drain(20);

    // 4: Req1 streams 20 bytes with no last; forced off after 16, Req0 next
    tick();
    base = push_total;
    err_cnt = 0;
    for (int i = 0; i < 20; i++) ld_src(1, 8'(8'h80 + i), 0);
    ld_src(0, 8'h99, 1);
    for (int i = 0; i < 16; i++) ld_exp(1, 8'(8'h80 + i));
    ld_exp(0, 8'h99);
    for (int i = 16; i < 20; i++) ld_exp(1, 8'(8'h80 + i));
    wait_drain(100);
    check("t4_err_pulses", err_cnt, 1);
    check("t4_pushes_before_err", push_at_err - base, 16);
    @(negedge clk);
    @(negedge clk);
    check("t4_grant_held_busy", {31'b0, busy}, 1);
    check("t4_grant_held_id", {31'b0, grant_id}, 1);

    // 5: reset mid-message
    tick();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check_reset_outputs("t5_rst_a");
    tick();
    tick();
    rst = 1'b0;
    tick();
    c0 = cyc;
    ld_src(0, 8'hA0, 0); ld_src(0, 8'hA1, 0); ld_src(0, 8'hA2, 0); ld_src(0, 8'hA3, 1);
    ld_exp(0, 8'hA0); ld_exp(0, 8'hA1);
    wait_tick(c0 + 4);
    rst = 1'b1;
    q0.delete();
    #1;
    check_reset_outputs("t5_rst_b");
    check("t5_partial_pushed", exp_q.size(), 0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_after_busy", {31'b0, busy}, 0);
    end

    // 6: owner pauses 3 cycles while Req1 waits
    tick();
    c0 = cyc;
    ld_src(0, 8'hC0, 0); ld_src(0, 8'hC1, 0); ld_src(0, 8'hC2, 1);
    ld_src(1, 8'hD0, 1);
    ld_exp(0, 8'hC0); ld_exp(0, 8'hC1); ld_exp(0, 8'hC2); ld_exp(1, 8'hD0);
    wait_tick(c0 + 2);
    mask = 2'b01;
    at_neg(c0 + 3);
    check("t6_gap_push_a", {31'b0, fifo_push}, 0);
    check("t6_gap_ready_a", {30'b0, req_ready}, 0);
    check("t6_gap_grant_a", {31'b0, grant_id}, 0);
    at_neg(c0 + 4);
    check("t6_gap_push_b", {31'b0, fifo_push}, 0);
    check("t6_gap_busy_b", {31'b0, busy}, 1);
    wait_tick(c0 + 5);
    mask = 2'b00;
    at_neg(c0 + 5);
    check("t6_gap_push_c", {31'b0, fifo_push}, 0);
    check("t6_gap_grant_c", {31'b0, grant_id}, 0);
    wait_drain(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
